// File: rtl/instr_loader.sv
// Boot-time program loader: turns a framed byte stream into 32-bit instruction-memory writes
// and holds the CPU until the whole image is written and its checksum matches.
module instr_loader #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    input  logic                  start,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error
);

    localparam logic [2:0] S_CNT_HI = 3'd0;
    localparam logic [2:0] S_CNT_LO = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_CSUM   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam logic [16:0] MAX_WORDS = 17'(1 << ADDR_WIDTH);

    logic [2:0]            r_state;
    logic [15:0]           r_cnt;
    logic [DATA_WIDTH-9:0] r_word;
    logic [1:0]            r_bcnt;
    logic [ADDR_WIDTH:0]   r_widx;
    logic [7:0]            r_csum;

    logic [2:0]            w_next;
    logic                  w_accept;
    logic [15:0]           w_cnt_new;
    logic [DATA_WIDTH-1:0] w_word_new;
    logic                  w_last_word;
    logic                  w_ready_next;

    assign w_accept    = byte_valid && byte_ready;
    assign w_cnt_new   = {r_cnt[15:8], byte_in};
    assign w_word_new  = {r_word, byte_in};
    // Index is one bit wider than the address so a full 2**ADDR_WIDTH image never wraps.
    assign w_last_word = (17'(r_widx) == (17'(r_cnt) - 17'd1));
    assign w_ready_next = (w_next == S_CNT_HI) || (w_next == S_CNT_LO) ||
                          (w_next == S_DATA)   || (w_next == S_CSUM);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CNT_HI: if (w_accept) w_next = S_CNT_LO;
            S_CNT_LO: begin
                if (w_accept) begin
                    if (w_cnt_new == 16'd0)
                        w_next = S_CSUM;
                    else if ({1'b0, w_cnt_new} > MAX_WORDS)
                        w_next = S_ERR;
                    else
                        w_next = S_DATA;
                end
            end
            S_DATA:   if (w_accept && (r_bcnt == 2'd3)) w_next = S_WRITE;
            S_WRITE:  w_next = w_last_word ? S_CSUM : S_DATA;
            S_CSUM:   if (w_accept) w_next = (byte_in == r_csum) ? S_DONE : S_ERR;
            S_DONE,
            S_ERR:    if (start) w_next = S_CNT_HI;
            default:  w_next = S_CNT_HI;
        endcase
    end

    // All flags are derived from the next state so every output is a plain register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_CNT_HI;
            r_cnt      <= '0;
            r_word     <= '0;
            r_bcnt     <= '0;
            r_widx     <= '0;
            r_csum     <= '0;
            byte_ready <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            r_state    <= w_next;
            byte_ready <= w_ready_next;
            mem_we     <= (w_next == S_WRITE);
            cpu_hold   <= (w_next != S_DONE);
            load_done  <= (w_next == S_DONE);
            load_error <= (w_next == S_ERR);

            case (r_state)
                S_CNT_HI: if (w_accept) r_cnt[15:8] <= byte_in;
                S_CNT_LO: if (w_accept) r_cnt[7:0]  <= byte_in;
                S_DATA: begin
                    if (w_accept) begin
                        r_word <= w_word_new[DATA_WIDTH-9:0];
                        r_csum <= r_csum + byte_in;
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            mem_addr <= r_widx[ADDR_WIDTH-1:0];
                            mem_data <= w_word_new;
                        end
                    end
                end
                S_WRITE: r_widx <= r_widx + 1'b1;
                S_DONE,
                S_ERR: begin
                    if (start) begin
                        r_cnt  <= '0;
                        r_bcnt <= '0;
                        r_widx <= '0;
                        r_csum <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader: frames are built from word lists, and the expected
// writes and final status come from the frame rules, checked by one negedge monitor.
module tb_instr_loader;

    localparam int AW   = 9;
    localparam int NMAX = 512;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    byte_in = 8'h00;
    logic          byte_valid = 1'b0;
    logic          start = 1'b0;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;

    instr_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .start      (start),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_err = 0;
    logic [AW-1:0] exp_addr_q[$];
    logic [31:0]   exp_data_q[$];
    int            wr_cnt = 0;
    logic [AW-1:0] last_addr = '0;
    logic [31:0]   last_data = '0;
    logic          prev_we = 1'b0;
    logic [31:0]   fw [NMAX];
    logic [7:0]    model_csum = 8'h00;
    bit            need_start = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write must be the next one the frame model predicts.
    always @(negedge clk) begin
        logic [AW-1:0] ea;
        logic [31:0]   ed;
        if (rst_n) begin
            chk("hold_vs_done", cpu_hold, !load_done);
            if (mem_we) begin
                chk("we_single_cycle", prev_we, 1'b0);
                chk("ready_low_in_write", byte_ready, 1'b0);
                chk("write_expected", exp_addr_q.size() != 0, 1'b1);
                if (exp_addr_q.size() != 0) begin
                    ea = exp_addr_q.pop_front();
                    ed = exp_data_q.pop_front();
                    chk("wr_addr", mem_addr, ea);
                    chk("wr_data", mem_data, ed);
                end
                wr_cnt++;
                last_addr = mem_addr;
                last_data = mem_data;
            end
            prev_we = mem_we;
        end else begin
            prev_we = 1'b0;
        end
    end

    task automatic check_reset_vals();
        chk("rst_byte_ready", byte_ready, 1'b1);
        chk("rst_cpu_hold", cpu_hold, 1'b1);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_load_done", load_done, 1'b0);
        chk("rst_load_error", load_error, 1'b0);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        bit acc;
        acc = 1'b0;
        byte_in = b;
        for (int k = 0; k < 200 && !acc; k++) begin
            byte_valid = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = byte_valid && byte_ready;
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
        chk("byte_accepted", acc, 1'b1);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("start_hold", cpu_hold, 1'b1);
        chk("start_done_clr", load_done, 1'b0);
        chk("start_err_clr", load_error, 1'b0);
        chk("start_ready", byte_ready, 1'b1);
    endtask

    task automatic wait_end();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            seen = load_done || load_error;
        end
        chk("frame_end_seen", seen, 1'b1);
    endtask

    task automatic begin_frame();
        if (need_start) pulse_start();
        else begin
            @(posedge clk);
            #1;
        end
    endtask

    // Frame of n words taken from fw[]; bad=1 sends a checksum one above the true sum.
    task automatic run_frame(input int n, input bit bad);
        logic [7:0] sum;
        logic [15:0] cnt;
        int w0;
        begin_frame();
        w0 = wr_cnt;
        cnt = 16'(n);
        send_byte(cnt[15:8]);
        send_byte(cnt[7:0]);
        if (n > NMAX) begin
            wait_end();
            chk("over_done", load_done, 1'b0);
            chk("over_error", load_error, 1'b1);
            chk("over_hold", cpu_hold, 1'b1);
            chk("over_no_writes", wr_cnt - w0, 0);
        end else begin
            sum = 8'h00;
            for (int i = 0; i < n; i++) begin
                exp_addr_q.push_back(AW'(i));
                exp_data_q.push_back(fw[i]);
                for (int j = 0; j < 4; j++) sum = sum + fw[i][31-8*j -: 8];
            end
            model_csum = sum;
            for (int i = 0; i < n; i++)
                for (int j = 0; j < 4; j++) send_byte(fw[i][31-8*j -: 8]);
            send_byte(sum + 8'(bad));
            wait_end();
            chk("end_done", load_done, !bad);
            chk("end_error", load_error, bad);
            chk("end_hold", cpu_hold, bad);
            chk("write_count", wr_cnt - w0, n);
            chk("queue_drained", exp_addr_q.size(), 0);
        end
        need_start = 1'b1;
    endtask

    task automatic abort_with_reset();
        begin_frame();
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(fw[0][31:24]);
        send_byte(fw[0][23:16]);
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        need_start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit bad;
        #12 check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;

        fw[0] = 32'h08010004;
        run_frame(1, 1'b0);
        chk("A_model_csum", model_csum, 8'h0D);
        chk("A_last_addr", last_addr, 0);
        chk("A_last_data", last_data, 32'h08010004);

        fw[1] = 32'h081F0036;
        run_frame(2, 1'b0);
        chk("B_model_csum", model_csum, 8'h6A);
        chk("B_last_addr", last_addr, 1);
        chk("B_last_data", last_data, 32'h081F0036);

        run_frame(2, 1'b1);
        run_frame(1, 1'b0);
        run_frame(513, 1'b0);
        run_frame(0, 1'b0);
        run_frame(0, 1'b1);

        for (int f = 0; f < 16; f++) begin
            n = ($urandom_range(0, 6) == 0) ? int'($urandom_range(513, 65535)) : int'($urandom_range(0, 8));
            bad = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 8; i++) fw[i] = $urandom;
            run_frame(n, bad);
        end

        for (int i = 0; i < 3; i++) fw[i] = $urandom | 32'h1;
        run_frame(3, 1'b0);
        chk("pre_abort_addr", last_addr, 2);
        abort_with_reset();

        fw[0] = 32'h08010004;
        fw[1] = 32'h081F0036;
        run_frame(2, 1'b0);
        chk("post_abort_last", last_data, 32'h081F0036);

        for (int i = 0; i < NMAX; i++) fw[i] = $urandom;
        run_frame(NMAX, 1'b0);
        chk("full_last_addr", last_addr, NMAX - 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
